uart_rx_core: RTL and testbench

UART receiver (8N1) converting the serial rs232_rx line into parallel bytes for the SDRAM test datapath. Synchronises the asynchronous line, detects a start bit, samples each bit at mid-bit, checks the stop bit, and emits a one-cycle rx_done strobe with the byte. Pairs with the design's uart_tx block at the same baud rate.

---
 rtl/uart_rx_core.sv | 148 ++++++++++++++
 tb/tb_uart_rx_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises rs232_rx, samples each bit at mid-bit and
// emits a one-cycle rx_done (with rx_data) or frame_err strobe per frame.
module uart_rx_core #(
    parameter int BAUD_END = 5208,
    parameter int BAUD_MID = 2604,
    parameter int BIT_END  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam logic [12:0] END_M1    = 13'(BAUD_END - 1);
    localparam logic [12:0] MID_M1    = 13'(BAUD_MID - 1);
    localparam logic [3:0]  LAST_DATA = 4'(BIT_END - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt0_q, cnt0_d;
    logic [3:0]  cnt1_q, cnt1_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;
    logic        r1_q, r2_q, r3_q;
    logic [1:0]  flush_q;
    logic        armed_q;
    logic        falling;
    logic        at_mid;
    logic        at_end;

    // The sync flops reset to 1, so a line already low at reset release would
    // look like a falling edge. Starts are only accepted once r2 has carried a
    // real high level from the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q    <= 1'b1;
            r2_q    <= 1'b1;
            r3_q    <= 1'b1;
            flush_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            r1_q    <= rs232_rx;
            r2_q    <= r1_q;
            r3_q    <= r2_q;
            if (flush_q != 2'd2) begin
                flush_q <= flush_q + 2'd1;
            end
            armed_q <= armed_q | ((flush_q == 2'd2) & r2_q);
        end
    end

    assign falling = armed_q & ~r2_q & r3_q;
    assign at_mid  = (cnt0_q == MID_M1);
    assign at_end  = (cnt0_q == END_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt0_q      <= 13'd0;
            cnt1_q      <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt0_d = 13'd0;
                if (falling) begin
                    state_d = START;
                end
            end
            START: begin
                cnt0_d = at_end ? 13'd0 : cnt0_q + 13'd1;
                if (at_mid && r2_q) begin
                    state_d = IDLE;
                    cnt0_d  = 13'd0;
                end else if (at_end) begin
                    state_d = DATA;
                    cnt1_d  = 4'd0;
                end
            end
            DATA: begin
                cnt0_d = at_end ? 13'd0 : cnt0_q + 13'd1;
                if (at_mid) begin
                    shift_d[cnt1_q[2:0]] = r2_q;
                end
                if (at_end) begin
                    cnt1_d = cnt1_q + 4'd1;
                    if (cnt1_q == LAST_DATA) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                cnt0_d = cnt0_q + 13'd1;
                if (at_mid) begin
                    state_d = IDLE;
                    cnt0_d  = 13'd0;
                    if (r2_q) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt0_d  = 13'd0;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a shortened bit period; a negedge
// monitor records strobes and every comparison goes through check_eq.
module tb_uart_rx_core;

    localparam int BE = 64;
    localparam int BM = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int done_cyc = 0;
    logic       prev_act = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_core #(
        .BAUD_END (BE),
        .BAUD_MID (BM),
        .BIT_END  (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            check_eq("strobe_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            check_eq("strobe_one_cycle", {31'd0, prev_act}, 32'd0);
        end
        prev_act = rx_done | frame_err;
        if (rx_done === 1'b1) begin
            done_cnt++;
            got_q.push_back(rx_data);
            done_cyc = cyc;
            $display("rx_done  data=0x%02h cycle=%0d", rx_data, cyc);
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            $display("frame_err data=0x%02h cycle=%0d", rx_data, cyc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rs232_rx = v;
        wait_cyc(BE);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        stop_cyc = cyc;
        send_bit(stop);
    endtask

    initial begin
        logic [7:0] aborted;
        aborted  = 8'h6A;
        rs232_rx = 1'b1;
        rst_n    = 1'b0;
        wait_cyc(5);
        check_eq("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;

        // Idle line
        wait_cyc(2000);
        check_eq("idle_done_cnt", done_cnt, 0);
        check_eq("idle_err_cnt", err_cnt, 0);
        check_eq("idle_rx_data", {24'd0, rx_data}, 32'h00);

        // Single frame with latency from the stop bit's leading edge
        send_byte(8'h55, 1'b1);
        wait_cyc(BE);
        check_eq("f55_done_cnt", done_cnt, 1);
        check_eq("f55_data", {24'd0, got_q[0]}, 32'h55);
        check_eq("f55_latency", done_cyc - stop_cyc, BM + 3);
        check_eq("f55_rx_data_held", {24'd0, rx_data}, 32'h55);

        // Back-to-back frames
        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_cyc(BE);
        check_eq("b2b_done_cnt", done_cnt, 4);
        check_eq("b2b_data0", {24'd0, got_q[1]}, 32'hA3);
        check_eq("b2b_data1", {24'd0, got_q[2]}, 32'h0F);
        check_eq("b2b_data2", {24'd0, got_q[3]}, 32'hFF);

        // Short low glitch, then a valid frame
        rs232_rx = 1'b0;
        wait_cyc(12);
        rs232_rx = 1'b1;
        wait_cyc(3 * BE);
        check_eq("glitch_done_cnt", done_cnt, 4);
        check_eq("glitch_err_cnt", err_cnt, 0);
        send_byte(8'h3C, 1'b1);
        wait_cyc(BE);
        check_eq("f3c_done_cnt", done_cnt, 5);
        check_eq("f3c_data", {24'd0, got_q[4]}, 32'h3C);

        // Stop bit forced low, line then stuck low
        send_byte(8'h81, 1'b0);
        wait_cyc(3 * BE);
        check_eq("ferr_err_cnt", err_cnt, 1);
        check_eq("ferr_done_cnt", done_cnt, 5);
        check_eq("ferr_rx_data_kept", {24'd0, rx_data}, 32'h3C);
        rs232_rx = 1'b1;
        wait_cyc(2 * BE);
        check_eq("ferr_recover_err_cnt", err_cnt, 1);

        // Reset during data bit 4, line held low after release
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(aborted[i]);
        rs232_rx = aborted[4];
        wait_cyc(BM / 2);
        rst_n = 1'b0;
        wait_cyc(4);
        check_eq("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        check_eq("midreset_rx_done", {31'd0, rx_done}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(12 * BE);
        check_eq("abort_done_cnt", done_cnt, 5);
        check_eq("abort_err_cnt", err_cnt, 1);
        rs232_rx = 1'b1;
        wait_cyc(2 * BE);
        send_byte(8'hC6, 1'b1);
        wait_cyc(BE);
        check_eq("fc6_done_cnt", done_cnt, 6);
        check_eq("fc6_data", {24'd0, got_q[5]}, 32'hC6);
        check_eq("fc6_rx_data", {24'd0, rx_data}, 32'hC6);
        check_eq("fc6_err_cnt", err_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
